// File: rtl/mem_request_buffer.sv
// mem_request_buffer
//   In-order request buffer in front of the memory controller. Host requests
//   (read or write) are queued in a small FIFO and issued one at a time onto the
//   controller's segregated write / read channels. A read blocks the issuer
//   until its data comes back after RD_LAT cycles and the host has taken the
//   response, so every access reaches memory in arrival order.
//
// Ports
//   clock, reset                 shared with the controller; reset is async, active low
//   req_valid/req_ready          host request handshake (req_ready = FIFO not full)
//   req_write/req_addr/req_wdata request payload (wdata ignored for reads)
//   wr_address/wr_data/wr_enable write channel, registered, one-cycle strobe
//   rd_address/rd_enable         read channel, registered, one-cycle strobe
//   rd_data                      read data, valid RD_LAT cycles after rd_enable
//   rsp_valid/rsp_ready/rsp_rdata read response handshake
//   level                        current FIFO occupancy
//
// Optional build: define MEM_REQ_BUF_STATS_EN to add saturating 16-bit
//   wr_count / rd_count outputs counting issued write / read strobes.
module mem_request_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic [ADDR_W-1:0]          wr_address,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       wr_enable,
  output logic [ADDR_W-1:0]          rd_address,
  output logic                       rd_enable,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [$clog2(DEPTH):0]     level
`ifdef MEM_REQ_BUF_STATS_EN
  ,
  output logic [15:0]                wr_count,
  output logic [15:0]                rd_count
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int LAT_W = 3;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT_RD, RSP_HOLD} state_t;

  // ---------------- FIFO ----------------
  req_t          fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  req_t          head;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level     = wr_ptr - rd_ptr;
  assign req_ready = !full;
  // Full blocks the push even if the head pops in the same cycle (no bypass).
  assign push      = req_valid && !full;
  assign head      = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= '{write: req_write, addr: req_addr, data: req_wdata};
  end

  // ---------------- issuer FSM ----------------
  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_q;
  logic               can_issue, issue_wr, issue_rd, sample, rsp_clr;

  always_comb begin
    state_d   = state_q;
    can_issue = 1'b0;
    issue_wr  = 1'b0;
    issue_rd  = 1'b0;
    pop       = 1'b0;
    sample    = 1'b0;
    rsp_clr   = 1'b0;
    case (state_q)
      IDLE:     can_issue = 1'b1;
      WAIT_RD:  if (lat_q == '0) begin
                  sample  = 1'b1;
                  state_d = RSP_HOLD;
                end
      RSP_HOLD: if (rsp_ready) begin
                  // Handshake edge may also issue, so the next strobe lands
                  // in the cycle right after the handshake.
                  rsp_clr   = 1'b1;
                  state_d   = IDLE;
                  can_issue = 1'b1;
                end
      default:  state_d = IDLE;
    endcase
    if (can_issue && !empty) begin
      pop = 1'b1;
      if (head.write) begin
        issue_wr = 1'b1;
      end else begin
        issue_rd = 1'b1;
        state_d  = WAIT_RD;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state_q    <= IDLE;
      lat_q      <= '0;
      wr_enable  <= 1'b0;
      rd_enable  <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      rd_address <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      state_q   <= state_d;
      wr_enable <= issue_wr;
      rd_enable <= issue_rd;
      if (issue_wr) begin
        wr_address <= head.addr;
        wr_data    <= head.data;
      end
      if (issue_rd) rd_address <= head.addr;
      // Counter reaches zero in cycle T+RD_LAT, when rd_data is sampled.
      if (issue_rd)                                lat_q <= LAT_W'(RD_LAT);
      else if (state_q == WAIT_RD && lat_q != '0)  lat_q <= lat_q - 1'b1;
      if (sample) begin
        rsp_rdata <= rd_data;
        rsp_valid <= 1'b1;
      end else if (rsp_clr) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef MEM_REQ_BUF_STATS_EN
  // ---------------- saturating strobe counters ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_enable && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (rd_enable && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_request_buffer.sv
// Directed testbench for mem_request_buffer (DEPTH=4, RD_LAT=2).
// Edges are numbered e1, e2, ... from the start of each task; outputs are
// sampled 1 time unit after each rising edge, inputs are changed there too.
module tb_mem_request_buffer;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 2;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0, req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready;
  logic [ADDR_W-1:0] wr_address, rd_address;
  logic [DATA_W-1:0] wr_data, rd_data, rsp_rdata;
  logic              wr_enable, rd_enable, rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [LW-1:0]     level;
`ifdef MEM_REQ_BUF_STATS_EN
  logic [15:0]       wr_count, rd_count;
`endif

  int errors = 0;
  int checks = 0;

  mem_request_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .wr_address(wr_address), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_address(rd_address), .rd_enable(rd_enable), .rd_data(rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .level(level)
`ifdef MEM_REQ_BUF_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  always #5 clock = ~clock;

  // Model memory: writes land on wr_enable; read data is presented only in
  // cycle T+RD_LAT after rd_enable in cycle T, garbage otherwise.
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W:0]   rd_pipe [RD_LAT];
  always @(posedge clock) begin
    if (wr_enable) mem[wr_address[7:0]] <= wr_data;
    rd_pipe[0] <= {rd_enable, mem[rd_address[7:0]]};
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rd_data = rd_pipe[RD_LAT-1][DATA_W] ? rd_pipe[RD_LAT-1][DATA_W-1:0] : 32'hBAD0BAD0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    tick();
    checks++; if (level !== '0)       begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if ({wr_enable, rd_enable, rsp_valid} !== 3'b000)
      begin errors++; $display("FAIL reset_strobes got=%b exp=000", {wr_enable, rd_enable, rsp_valid}); end
    checks++; if ({wr_address, wr_data, rd_address, rsp_rdata} !== '0)
      begin errors++; $display("FAIL reset_data got=%h %h %h %h exp=0", wr_address, wr_data, rd_address, rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    logic exp_we;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, 1'b1, 32'h10 + 32'(i), 32'hA0 + 32'(i));
      else       drive(1'b0, 1'b0, '0, '0);
      tick();
      exp_we = (i >= 1 && i <= 4);
      checks++; if (wr_enable !== exp_we)
        begin errors++; $display("FAIL b2b_we[%0d] got=%b exp=%b", i, wr_enable, exp_we); end
      if (exp_we) begin
        checks++; if (wr_address !== 32'h10 + 32'(i-1) || wr_data !== 32'hA0 + 32'(i-1))
          begin errors++; $display("FAIL b2b_wr[%0d] got=%h/%h exp=%h/%h", i, wr_address, wr_data, 32'h10 + 32'(i-1), 32'hA0 + 32'(i-1)); end
      end
      checks++; if (level !== LW'(i < 4 ? 1 : 0))
        begin errors++; $display("FAIL b2b_level[%0d] got=%0d exp=%0d", i, level, (i < 4 ? 1 : 0)); end
    end
  endtask

  task automatic test_raw();
    rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 32'h20, 32'hDEAD);
    tick();                                    // e1: write pushed
    drive(1'b1, 1'b0, 32'h20, 32'h0);
    tick();                                    // e2: write issued, read pushed
    checks++; if (wr_enable !== 1'b1 || wr_address !== 32'h20 || wr_data !== 32'hDEAD)
      begin errors++; $display("FAIL raw_wr got=%b %h %h exp=1 20 dead", wr_enable, wr_address, wr_data); end
    drive(1'b0, 1'b0, '0, '0);
    tick();                                    // e3: read issued
    checks++; if (rd_enable !== 1'b1 || rd_address !== 32'h20 || wr_enable !== 1'b0)
      begin errors++; $display("FAIL raw_rd got=%b %h we=%b exp=1 20 we=0", rd_enable, rd_address, wr_enable); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (rsp_valid !== (k == 3))
        begin errors++; $display("FAIL raw_rspv[%0d] got=%b exp=%b", k, rsp_valid, (k == 3)); end
      if (k == 3) begin
        checks++; if (rsp_rdata !== 32'hDEAD)
          begin errors++; $display("FAIL raw_rdata got=%h exp=dead", rsp_rdata); end
      end
    end
  endtask

  task automatic test_stall();
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h20, 32'h0);
    tick();                                    // e1: read pushed
    drive(1'b1, 1'b1, 32'h30, 32'h55);
    tick();                                    // e2: read issued, write queued
    checks++; if (rd_enable !== 1'b1)
      begin errors++; $display("FAIL stall_rd got=%b exp=1", rd_enable); end
    drive(1'b0, 1'b0, '0, '0);
    repeat (2) tick();                         // e3, e4
    for (int s = 0; s < 5; s++) begin          // e5..e9: response held
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD || wr_enable !== 1'b0)
        begin errors++; $display("FAIL stall_hold[%0d] got=v%b %h we%b exp=v1 dead we0", s, rsp_valid, rsp_rdata, wr_enable); end
    end
    rsp_ready = 1'b1;
    tick();                                    // e10: handshake + write issue
    checks++; if (wr_enable !== 1'b1 || wr_address !== 32'h30 || rsp_valid !== 1'b0)
      begin errors++; $display("FAIL stall_release got=we%b %h v%b exp=we1 30 v0", wr_enable, wr_address, rsp_valid); end
    tick();
    checks++; if (wr_enable !== 1'b0)
      begin errors++; $display("FAIL stall_after got=%b exp=0", wr_enable); end
  endtask

  task automatic test_full();
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h20, 32'h0);
    tick();                                    // e1: read pushed
    for (int w = 0; w < 4; w++) begin          // e2..e5: four writes queue
      drive(1'b1, 1'b1, 32'h50 + 32'(w), 32'hB0 + 32'(w));
      tick();
    end
    checks++; if (level !== LW'(4) || req_ready !== 1'b0 || rsp_valid !== 1'b1)
      begin errors++; $display("FAIL full_level got=%0d rdy=%b v=%b exp=4 0 1", level, req_ready, rsp_valid); end
    drive(1'b1, 1'b1, 32'h54, 32'hB4);
    tick();                                    // e6: push refused
    checks++; if (level !== LW'(4) || req_ready !== 1'b0 || rsp_rdata !== 32'hDEAD)
      begin errors++; $display("FAIL full_hold got=%0d rdy=%b %h exp=4 0 dead", level, req_ready, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();                                    // e7: pop while full, push still refused
    checks++; if (level !== LW'(3) || req_ready !== 1'b1 || wr_enable !== 1'b1 || wr_address !== 32'h50)
      begin errors++; $display("FAIL full_pop got=%0d rdy=%b we=%b %h exp=3 1 1 50", level, req_ready, wr_enable, wr_address); end
    tick();                                    // e8: 0x54 accepted
    drive(1'b0, 1'b0, '0, '0);
    checks++; if (level !== LW'(3) || wr_address !== 32'h51 || wr_data !== 32'hB1)
      begin errors++; $display("FAIL full_push got=%0d %h %h exp=3 51 b1", level, wr_address, wr_data); end
    for (int k = 2; k <= 4; k++) begin         // e9..e11: drain across the wrap
      tick();
      checks++; if (wr_enable !== 1'b1 || wr_address !== 32'h50 + 32'(k) || wr_data !== 32'hB0 + 32'(k) || level !== LW'(4 - k))
        begin errors++; $display("FAIL full_drain[%0d] got=%b %h %h l%0d exp=1 %h %h l%0d", k, wr_enable, wr_address, wr_data, level, 32'h50 + 32'(k), 32'hB0 + 32'(k), 4 - k); end
    end
    tick();
    checks++; if (wr_enable !== 1'b0)
      begin errors++; $display("FAIL full_end got=%b exp=0", wr_enable); end
  endtask

  task automatic test_reset_mid_read();
    rsp_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    tick();                                    // read issued
    tick();                                    // now waiting on read data
    reset = 1'b0;
    #1;
    checks++; if ({wr_enable, rd_enable, rsp_valid} !== 3'b000 || level !== '0)
      begin errors++; $display("FAIL rst_mid_ctl got=%b l%0d exp=000 l0", {wr_enable, rd_enable, rsp_valid}, level); end
    checks++; if ({wr_address, wr_data, rd_address, rsp_rdata} !== '0)
      begin errors++; $display("FAIL rst_mid_data got=%h %h %h %h exp=0", wr_address, wr_data, rd_address, rsp_rdata); end
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0 || level !== '0 || req_ready !== 1'b1)
        begin errors++; $display("FAIL rst_mid_after[%0d] got=v%b l%0d r%b exp=v0 l0 r1", k, rsp_valid, level, req_ready); end
    end
  endtask

`ifdef MEM_REQ_BUF_STATS_EN
  task automatic test_stats();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i < 3), 32'h60 + 32'(i), 32'hC0 + 32'(i));
      tick();
    end
    drive(1'b0, 1'b0, '0, '0);
    repeat (20) tick();
    checks++; if (wr_count !== 16'd3 || rd_count !== 16'd2)
      begin errors++; $display("FAIL stats_count got=%0d/%0d exp=3/2", wr_count, rd_count); end
    force dut.wr_count = 16'hFFFF;
    tick();
    release dut.wr_count;
    drive(1'b1, 1'b1, 32'h70, 32'h1);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    repeat (3) tick();
    checks++; if (wr_count !== 16'hFFFF)
      begin errors++; $display("FAIL stats_sat got=%h exp=ffff", wr_count); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_raw();
    test_stall();
    test_full();
    test_reset_mid_read();
`ifdef MEM_REQ_BUF_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_request_buffer.md
# mem_request_buffer

Request buffer and sequencer directly upstream of the memory controller. Accepts a single host request stream (read or write) over a valid/ready handshake, buffers it in a small in-order FIFO, and drives the segregated write and read channels of the controller. It captures read data after a fixed latency and returns it on a valid/ready response port. It shares the controller's clock and reset.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DEPTH, 4, FIFO entries; power of two, >= 2
- RD_LAT, 1, cycles from rd_enable to rd_data valid; 1..7
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  buffer can accept (= not full)
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data (ignored for reads)
- wr_address  out  ADDR_W  write-channel address
- wr_data  out  DATA_W  write-channel data
- wr_enable  out  1  one-cycle write strobe
- rd_address  out  ADDR_W  read-channel address
- rd_enable  out  1  one-cycle read strobe
- rd_data  in  DATA_W  read-channel data
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  DATA_W  read response data
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Push: req_valid && req_ready stores {write, addr, wdata} at tail. req_ready = (level != DEPTH); no bypass of a full FIFO, even if a pop happens in the same cycle.
- Pointers are $clog2(DEPTH)+1 bits with wrap bit; full/empty from pointer compare; wrap-around at DEPTH-1 -> 0.
- Issuer FSM, strictly in order:
  - IDLE: head is write -> drive wr_address/wr_data, wr_enable=1 for one cycle, pop; stay IDLE. Head is read -> drive rd_address, rd_enable=1 for one cycle, pop, go WAIT_RD, load latency counter with RD_LAT. Empty -> no strobe.
  - WAIT_RD: counter decrements each cycle; at zero, sample rd_data into rsp_rdata, set rsp_valid, go RSP_HOLD.
  - RSP_HOLD: hold rsp_valid/rsp_rdata stable until rsp_ready; on handshake clear rsp_valid, go IDLE.
- No issue in WAIT_RD or RSP_HOLD; writes behind a read wait, preserving read-after-write and write-after-read order.
- Simultaneous push and pop: level unchanged, both take effect.
- wr_address/wr_data/rd_address are registered and hold their last value when strobes are low.

## Timing
- Reset (asynchronous, reset low): FIFO empty, level=0, FSM IDLE, req_ready=1 after reset releases, wr_enable=rd_enable=rsp_valid=0, all address/data outputs 0. In-flight read is discarded; no response is produced.
- Push at edge N: entry visible cycle N+1; strobe for it asserted cycle N+1 at earliest (registered outputs).
- Back-to-back writes: one wr_enable per cycle with continuous input.
- Read: rd_enable high cycle T; rd_data sampled at the end of cycle T+RD_LAT; rsp_valid high from cycle T+RD_LAT+1.
- After rsp handshake in cycle H, the next strobe is earliest in cycle H+1.
- level updates on the edge of push/pop.

## Configuration
- MEM_REQ_BUF_STATS_EN defined: adds outputs wr_count and rd_count (16 bits each). Each increments on wr_enable or rd_enable respectively, saturates at 16'hFFFF, and resets to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset low mid-read (in WAIT_RD) -> all outputs 0 at once; after release, rsp_valid never rises for the discarded read and level=0.
- Push 4 writes addr 0x10..0x13, data 0xA0..0xA3, on consecutive cycles -> wr_enable high 4 consecutive cycles starting one cycle after the first push, with matching addr/data; level peaks at 1.
- Write 0x20<-0xDEAD, then read 0x20 with RD_LAT=2 and a model memory -> rd_enable 1 cycle after wr_enable; rsp_valid 3 cycles after rd_enable; rsp_rdata=0xDEAD.
- Hold rsp_ready=0 for 5 cycles with a queued write behind the read -> rsp_rdata is stable; wr_enable is suppressed until the cycle after the handshake.
- Fill DEPTH=4 while stalled -> req_ready=0 at level 4; a push attempted during the same-cycle pop is not accepted; after pop, req_ready=1 and pointer wrap preserves order.
- Stats build: 3 writes + 2 reads -> wr_count=3, rd_count=2; forced count 0xFFFF then one more write -> remains 0xFFFF.
